truth_table_checker: RTL and testbench
======================================

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter N_IN, default 2, number of DUT inputs (legal 1..8).
REQ-002 Parameter SETTLE, default 2, cycles each vector is held before sampling (legal 1..255).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  begin exhaustive sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate sweep; return to IDLE without done.
REQ-007 expected  input  2**N_IN  golden truth table; bit i = required dut_y for stim==i.
REQ-008 stim  output  N_IN  vector driven to DUT inputs.
REQ-009 dut_y  input  1  DUT response.
REQ-010 busy  output  1  high in APPLY or SAMPLE.
REQ-011 done  output  1  one-cycle pulse at sweep completion.
REQ-012 pass  output  1  high when the last completed sweep had zero mismatches; held until next start.
REQ-013 err_count  output  N_IN+1  mismatches in current/last sweep.
REQ-014 first_fail  output  N_IN  index of first mismatching vector; valid when fail_seen=1.
REQ-015 fail_seen  output  1  at least one mismatch in current/last sweep.

Function
REQ-016 FSM states SHALL be IDLE, APPLY, SAMPLE, DONE.
REQ-017 IDLE: start=1 and abort=0 -> APPLY; latch expected into internal register; clear err_count, fail_seen, first_fail, pass; set stim=0.
REQ-018 APPLY: stim held; settle counter counts SETTLE cycles, then -> SAMPLE.
REQ-019 SAMPLE (one cycle): compare dut_y with latched expected[stim]; on mismatch, increment err_count, and if fail_seen=0 capture first_fail=stim, set fail_seen.
REQ-020 SAMPLE with stim < 2**N_IN-1 -> APPLY with stim+1; with stim == 2**N_IN-1 -> DONE.
REQ-021 DONE (one cycle): done=1, pass=(err_count==0 including final sample), stim wraps to 0, -> IDLE.
REQ-022 Sweep latency start-accepted to done SHALL be exactly 2**N_IN*(SETTLE+1)+1 cycles.
REQ-023 err_count SHALL NOT wrap; width N_IN+1 holds max 2**N_IN.
REQ-024 start while busy or in DONE SHALL be ignored.
REQ-025 abort in APPLY/SAMPLE -> IDLE next cycle; stim=0; done stays 0; pass stays 0; err_count, first_fail, fail_seen retain partial values.
REQ-026 Simultaneous start and abort in IDLE: abort wins, remain in IDLE.
REQ-027 Changes to expected during a sweep SHALL have no effect.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_seen=0, settle counter=0.
REQ-029 Reset mid-sweep SHALL discard the sweep; no done pulse after release.
REQ-030 First start is accepted on the first rising edge with rst_n=1.

Structure
REQ-031 Package truth_table_pkg SHALL hold the state encoding and default N_IN/SETTLE constants.
REQ-032 Settle counter SHALL be a sub-module settle_timer (load, count, expire pulse), parametrised by SETTLE.
REQ-033 Output-to-DUT path SHALL be registered; no combinational path from dut_y to stim.

Verification
REQ-034 N_IN=2, SETTLE=2, expected=4'b1000, DUT=AND -> stim 0,1,2,3 each held 3 cycles; done at cycle 13; pass=1, err_count=0, fail_seen=0.
REQ-035 Same but DUT=OR -> err_count=2, first_fail=1, fail_seen=1, pass=0.
REQ-036 N_IN=4, SETTLE=1, expected=16'h6996, DUT=XOR4 -> stim visits 0..15 in order, wraps to 0; pass=1 at cycle 33.
REQ-037 Abort asserted when stim=2 -> IDLE next cycle, no done, stim=0; new start runs a full clean sweep.
REQ-038 rst_n pulsed low mid-APPLY -> all outputs zero immediately; start pulsed during busy -> ignored, latency unchanged.
REQ-039 start and abort together in IDLE -> busy stays 0.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared constants and FSM encoding for the truth-table sweep checker.
package truth_table_pkg;

  localparam int TT_N_IN  = 2;
  localparam int TT_SETTLE = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

endpackage

// File: rtl/truth_table_checker_if.sv
// Sweep control, golden table and DUT-facing signals of the truth-table checker.
interface truth_table_checker_if #(
  parameter int N_IN = 2
);
  logic                 start;
  logic                 abort;
  logic [2**N_IN-1:0]   expected;
  logic [N_IN-1:0]      stim;
  logic                 dut_y;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N_IN:0]        err_count;
  logic [N_IN-1:0]      first_fail;
  logic                 fail_seen;

  modport master (
    output start, abort, expected, dut_y,
    input  stim, busy, done, pass, err_count, first_fail, fail_seen
  );

  modport slave (
    input  start, abort, expected, dut_y,
    output stim, busy, done, pass, err_count, first_fail, fail_seen
  );
endinterface

// File: rtl/settle_timer.sv
// Down-counter that times how long a vector is held; expire marks the last hold cycle.
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (load)                  cnt <= CW'(SETTLE - 1);
    else if (count && cnt != '0)    cnt <= cnt - CW'(1);
  end

  assign expire = count && (cnt == '0);
endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive input sweep: drives every vector, samples the DUT response and
// compares it with a golden truth table latched at start.
module truth_table_checker
  import truth_table_pkg::*;
#(
  parameter int N_IN   = TT_N_IN,
  parameter int SETTLE = TT_SETTLE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_checker_if.slave  bus
);
  localparam int NV = 2**N_IN;
  localparam logic [N_IN-1:0] LAST = '1;

  tt_state_e         state, state_nxt;
  logic [NV-1:0]     exp_q;
  logic [N_IN-1:0]   stim_q, first_fail_q;
  logic [N_IN:0]     err_q;
  logic              fail_seen_q, pass_q;
  logic              busy, done, accept, sample_en, stop;
  logic              tmr_load, tmr_count, tmr_expire, mismatch;

  settle_timer #(.SETTLE(SETTLE)) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .count  (tmr_count),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && !bus.abort) state_nxt = APPLY;
      APPLY:   if (bus.abort)               state_nxt = IDLE;
               else if (tmr_expire)         state_nxt = SAMPLE;
      SAMPLE:  if (bus.abort)               state_nxt = IDLE;
               else if (stim_q == LAST)     state_nxt = DONE;
               else                         state_nxt = APPLY;
      DONE:                                 state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == APPLY) || (state == SAMPLE);
    done      = (state == DONE);
    accept    = (state == IDLE) && bus.start && !bus.abort;
    stop      = busy && bus.abort;
    // abort takes precedence over the sample it would otherwise land on
    sample_en = (state == SAMPLE) && !bus.abort;
    tmr_count = (state == APPLY);
    tmr_load  = accept || (sample_en && stim_q != LAST);
  end

  assign mismatch = bus.dut_y != exp_q[stim_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q        <= '0;
      stim_q       <= '0;
      err_q        <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
      pass_q       <= 1'b0;
    end else if (accept) begin
      exp_q        <= bus.expected;
      stim_q       <= '0;
      err_q        <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
      pass_q       <= 1'b0;
    end else if (sample_en) begin
      if (mismatch) begin
        if (err_q != '1) err_q <= err_q + (N_IN+1)'(1);
        if (!fail_seen_q) begin
          first_fail_q <= stim_q;
          fail_seen_q  <= 1'b1;
        end
      end
      // pass is settled on entry to DONE so it is valid alongside the done pulse
      if (stim_q == LAST) begin
        stim_q <= '0;
        pass_q <= (err_q == '0) && !mismatch;
      end else begin
        stim_q <= stim_q + N_IN'(1);
      end
    end else if (stop) begin
      stim_q <= '0;
    end
  end

  assign bus.stim       = stim_q;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = first_fail_q;
  assign bus.fail_seen  = fail_seen_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench: two checker instances (N_IN=2/SETTLE=2, N_IN=4/SETTLE=1)
// exercised with directed and random sweeps against a table-level model.
module tb_truth_table_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_r [2];
  logic        abort_r [2];
  logic [3:0]  exp_a, dut_a;
  logic [15:0] exp_b, dut_b;

  int stim_o [2], busy_o [2], done_o [2], pass_o [2];
  int err_o [2], ff_o [2], fs_o [2];

  int checks = 0;
  int errors = 0;

  truth_table_checker_if #(.N_IN(2)) ifa ();
  truth_table_checker_if #(.N_IN(4)) ifb ();

  truth_table_checker #(.N_IN(2), .SETTLE(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  truth_table_checker #(.N_IN(4), .SETTLE(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  // DUT models are plain lookup tables indexed by the checker's stimulus
  assign ifa.start    = start_r[0];
  assign ifa.abort    = abort_r[0];
  assign ifa.expected = exp_a;
  assign ifa.dut_y    = dut_a[ifa.stim];
  assign ifb.start    = start_r[1];
  assign ifb.abort    = abort_r[1];
  assign ifb.expected = exp_b;
  assign ifb.dut_y    = dut_b[ifb.stim];

  assign stim_o[0] = int'(ifa.stim);
  assign busy_o[0] = int'(ifa.busy);
  assign done_o[0] = int'(ifa.done);
  assign pass_o[0] = int'(ifa.pass);
  assign err_o[0]  = int'(ifa.err_count);
  assign ff_o[0]   = int'(ifa.first_fail);
  assign fs_o[0]   = int'(ifa.fail_seen);
  assign stim_o[1] = int'(ifb.stim);
  assign busy_o[1] = int'(ifb.busy);
  assign done_o[1] = int'(ifb.done);
  assign pass_o[1] = int'(ifb.pass);
  assign err_o[1]  = int'(ifb.err_count);
  assign ff_o[1]   = int'(ifb.first_fail);
  assign fs_o[1]   = int'(ifb.fail_seen);

  function automatic int ni(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic int se(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic set_tables(input int k, input logic [15:0] e, input logic [15:0] d);
    if (k == 0) begin exp_a = e[3:0]; dut_a = d[3:0]; end
    else        begin exp_b = e;      dut_b = d;      end
  endtask

  // Mismatch statistics over the first nvec vectors of a table pair.
  task automatic score(input logic [15:0] e, input logic [15:0] d, input int nvec,
                       output int ne, output int ff, output int fs);
    logic [15:0] m;
    m  = e ^ d;
    ne = 0; ff = 0; fs = 0;
    for (int i = 0; i < nvec; i++)
      if (((m >> i) & 16'd1) != 16'd0) begin
        if (fs == 0) ff = i;
        fs = 1;
        ne++;
      end
  endtask

  task automatic check_zero(input int k, input string tag);
    chk({tag, ".stim"}, stim_o[k], 0);
    chk({tag, ".busy"}, busy_o[k], 0);
    chk({tag, ".done"}, done_o[k], 0);
    chk({tag, ".pass"}, pass_o[k], 0);
    chk({tag, ".err"},  err_o[k],  0);
    chk({tag, ".ff"},   ff_o[k],   0);
    chk({tag, ".fs"},   fs_o[k],   0);
  endtask

  // Full sweep; poke>0 raises start during cycle poke of the sweep and during DONE.
  task automatic sweep(input int k, input logic [15:0] e, input logic [15:0] d, input int poke);
    int nv, per, lat, ne, ff, fs;
    nv  = 1 << ni(k);
    per = se(k) + 1;
    lat = nv * per + 1;
    score(e, d, nv, ne, ff, fs);
    set_tables(k, e, d);
    start_r[k] = 1'b1;
    @(negedge clk);
    start_r[k] = 1'b0;
    for (int c = 1; c < lat; c++) begin
      chk($sformatf("sw%0d.stim@%0d", k, c), stim_o[k], (c - 1) / per);
      chk($sformatf("sw%0d.busy@%0d", k, c), busy_o[k], 1);
      chk($sformatf("sw%0d.done@%0d", k, c), done_o[k], 0);
      if (c == 2) set_tables(k, 16'($urandom), d);
      start_r[k] = (c == poke);
      @(negedge clk);
    end
    chk($sformatf("sw%0d.done", k), done_o[k], 1);
    chk($sformatf("sw%0d.busy_end", k), busy_o[k], 0);
    chk($sformatf("sw%0d.stim_wrap", k), stim_o[k], 0);
    chk($sformatf("sw%0d.pass", k), pass_o[k], (ne == 0) ? 1 : 0);
    chk($sformatf("sw%0d.err", k), err_o[k], ne);
    chk($sformatf("sw%0d.fs", k), fs_o[k], fs);
    chk($sformatf("sw%0d.ff", k), ff_o[k], ff);
    start_r[k] = (poke > 0);
    @(negedge clk);
    start_r[k] = 1'b0;
    chk($sformatf("sw%0d.done_pulse", k), done_o[k], 0);
    chk($sformatf("sw%0d.idle_after", k), busy_o[k], 0);
    chk($sformatf("sw%0d.pass_held", k), pass_o[k], (ne == 0) ? 1 : 0);
    chk($sformatf("sw%0d.err_held", k), err_o[k], ne);
  endtask

  // Abort somewhere while vector stop is on stim; that vector is never scored.
  task automatic abort_sweep(input int k, input logic [15:0] e, input logic [15:0] d, input int stop);
    int per, c_ab, ne, ff, fs, seen;
    per  = se(k) + 1;
    c_ab = stop * per + 1 + int'($urandom_range(0, per - 1));
    score(e, d, stop, ne, ff, fs);
    set_tables(k, e, d);
    start_r[k] = 1'b1;
    @(negedge clk);
    start_r[k] = 1'b0;
    for (int c = 1; c < c_ab; c++) @(negedge clk);
    chk($sformatf("ab%0d.stim_pre", k), stim_o[k], stop);
    abort_r[k] = 1'b1;
    @(negedge clk);
    abort_r[k] = 1'b0;
    chk($sformatf("ab%0d.busy", k), busy_o[k], 0);
    chk($sformatf("ab%0d.stim", k), stim_o[k], 0);
    chk($sformatf("ab%0d.pass", k), pass_o[k], 0);
    chk($sformatf("ab%0d.err", k), err_o[k], ne);
    chk($sformatf("ab%0d.fs", k), fs_o[k], fs);
    chk($sformatf("ab%0d.ff", k), ff_o[k], ff);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o[k] != 0 || busy_o[k] != 0) seen = 1;
    end
    chk($sformatf("ab%0d.quiet", k), seen, 0);
  endtask

  task automatic start_abort(input int k);
    start_r[k] = 1'b1;
    abort_r[k] = 1'b1;
    @(negedge clk);
    start_r[k] = 1'b0;
    abort_r[k] = 1'b0;
    chk($sformatf("sa%0d.busy", k), busy_o[k], 0);
    @(negedge clk);
    chk($sformatf("sa%0d.busy2", k), busy_o[k], 0);
  endtask

  task automatic reset_mid(input int k);
    int seen;
    set_tables(k, 16'($urandom), 16'($urandom));
    start_r[k] = 1'b1;
    @(negedge clk);
    start_r[k] = 1'b0;
    repeat (int'($urandom_range(1, 6))) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero(0, "rst_mid_a");
    check_zero(1, "rst_mid_b");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_o[k] != 0 || busy_o[k] != 0) seen = 1;
    end
    chk($sformatf("rst%0d.no_done", k), seen, 0);
  endtask

  initial begin
    logic [15:0] e, d;
    int nv, lat;
    start_r[0] = 1'b0; start_r[1] = 1'b0;
    abort_r[0] = 1'b0; abort_r[1] = 1'b0;
    exp_a = '0; dut_a = '0; exp_b = '0; dut_b = '0;

    repeat (2) @(negedge clk);
    check_zero(0, "reset_a");
    check_zero(1, "reset_b");
    rst_n = 1'b1;

    // AND gate against its own table, then OR against the AND table
    sweep(0, 16'h0008, 16'h0008, 0);
    sweep(0, 16'h0008, 16'h000E, 5);
    sweep(1, 16'h6996, 16'h6996, 0);
    sweep(0, 16'h0000, 16'h000F, 0);
    sweep(1, 16'h0000, 16'hFFFF, 7);

    abort_sweep(0, 16'h0008, 16'h000E, 2);
    sweep(0, 16'h0008, 16'h0008, 0);
    abort_sweep(1, 16'($urandom), 16'($urandom), int'($urandom_range(0, 15)));

    start_abort(0);
    start_abort(1);

    for (int k = 0; k < 2; k++)
      repeat (4) begin
        nv  = 1 << ni(k);
        lat = nv * (se(k) + 1) + 1;
        e   = 16'($urandom);
        d   = ($urandom_range(0, 1) == 0) ? e : 16'($urandom);
        sweep(k, e, d, int'($urandom_range(0, lat - 2)));
      end

    reset_mid(1);
    sweep(0, 16'h0006, 16'h0006, 0);
    reset_mid(0);
    sweep(1, 16'($urandom), 16'($urandom), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
